// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency measurement scheduler.
package freq_pkg;

  localparam int unsigned CNT_W             = 32;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    GATE,
    SETTLE,
    CAPTURE
  } state_t;

endpackage

// File: rtl/freq_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after ptr, wrapping.
module freq_rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CHW    = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CHW-1:0]    ptr,
  output logic [CHW-1:0]    next_idx,
  output logic              any_valid
);

  logic [CHW-1:0] idx;

  // Scan farthest-first so the nearest enabled channel after ptr wins.
  always_comb begin
    next_idx  = '0;
    idx       = '0;
    any_valid = |mask;
    for (int i = int'(NUM_CH); i >= 1; i--) begin
      idx = CHW'((int'(ptr) + i) % int'(NUM_CH));
      if (mask[idx]) next_idx = idx;
    end
  end

endmodule

// File: rtl/freq_meas_sched.sv
// Measurement scheduler time-sharing one freq_count across NUM_CH channels.
// Optional stale-result check enabled by defining FREQ_STALE_CHK_EN.
module freq_meas_sched
  import freq_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CHW           = $clog2(NUM_CH),
  parameter int unsigned GW            = 24,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [GW-1:0]     gate_len,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic              door_out,
  output logic [CHW-1:0]    ch_sel,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic [CHW-1:0]    result_ch,
  output logic              result_valid,
  output logic              result_err
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

  state_t         state;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] pick;
  logic           pick_ok;
  logic [GW-1:0]  gate_cnt;
  logic [SW-1:0]  settle_cnt;

`ifdef FREQ_STALE_CHK_EN
  logic [CNT_W-1:0] snapshot;
`endif

  freq_rr_pick #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_pick (
    .mask      (ch_en),
    .ptr       (ptr),
    .next_idx  (pick),
    .any_valid (pick_ok)
  );

  // Scheduler FSM: select channel, open gate, let the counter publish, capture.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      ptr          <= CHW'(NUM_CH - 1);
      gate_cnt     <= '0;
      settle_cnt   <= '0;
      door_out     <= 1'b0;
      ch_sel       <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
`ifdef FREQ_STALE_CHK_EN
      snapshot     <= '0;
      result_err   <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (|ch_en)) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end
        SELECT: begin
          // Mask may have been cleared since it was last checked; abandon quietly.
          if (pick_ok) begin
            ch_sel   <= pick;
            ptr      <= pick;
            gate_cnt <= (gate_len == '0) ? GW'(1) : gate_len;
            door_out <= 1'b1;
            state    <= GATE;
`ifdef FREQ_STALE_CHK_EN
            snapshot <= cnt_in;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GATE: begin
          if (gate_cnt == GW'(1)) begin
            door_out   <= 1'b0;
            settle_cnt <= SW'(SETTLE_CYCLES);
            state      <= SETTLE;
          end else begin
            gate_cnt <= gate_cnt - GW'(1);
          end
        end
        SETTLE: begin
          // Capture registers load on the way into CAPTURE so result_valid aligns.
          if (settle_cnt == SW'(1)) begin
            result       <= cnt_in;
            result_ch    <= ch_sel;
            result_valid <= 1'b1;
`ifdef FREQ_STALE_CHK_EN
            result_err   <= (cnt_in == snapshot);
`endif
            state        <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        CAPTURE: begin
          if (cont_mode && (|ch_en)) begin
            state <= SELECT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          door_out <= 1'b0;
        end
      endcase
    end
  end

`ifndef FREQ_STALE_CHK_EN
  assign result_err = 1'b0;
`endif

endmodule
